// File: rtl/hline_move_ctrl.sv
// Motion sequencer for the horizontal line's Y counter chain: one-cycle up/dw/ld strobes, bounce between Y_MIN/Y_MAX.
// Latency: strobes are registered and appear the cycle after the qualifying frame/start/load_req.
module hline_move_ctrl #(
  parameter int unsigned STEP_FRAMES = 2,
  parameter logic [15:0] Y_MIN       = 16'd18,
  parameter logic [15:0] Y_MAX       = 16'd630,
  parameter logic [15:0] Y_INIT      = 16'd320
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame,
  input  logic        start,
  input  logic        stop,
  input  logic        pause,
  input  logic        load_req,
  input  logic [15:0] load_val,
  input  logic [15:0] y,
  output logic        up,
  output logic        dw,
  output logic        ld,
  output logic [15:0] d,
  output logic        dir,
  output logic        moving
);

  localparam int FW = $clog2(STEP_FRAMES) + 1;
  localparam logic [FW-1:0] FLAST = FW'(STEP_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    PAUSE = 2'd3
  } state_t;

  state_t        state, state_nx;
  logic [FW-1:0] fcnt, fcnt_nx;
  logic          up_nx, dw_nx, ld_nx, dir_nx;
  logic [15:0]   d_nx;
  logic [15:0]   clamp_val;

  always_comb begin
    clamp_val = load_val;
    if (load_val < Y_MIN)
      clamp_val = Y_MIN;
    else if (load_val > Y_MAX)
      clamp_val = Y_MAX;
  end

  // Priority: load_req > stop > pause > start > step; reset handled in the register.
  always_comb begin
    state_nx = state;
    fcnt_nx  = fcnt;
    up_nx    = 1'b0;
    dw_nx    = 1'b0;
    ld_nx    = 1'b0;
    d_nx     = d;
    dir_nx   = dir;
    if (load_req) begin
      ld_nx   = 1'b1;
      d_nx    = clamp_val;
      fcnt_nx = '0;
      // LOAD is a single-cycle state and never lingers
      if (state == LOAD)
        state_nx = RUN;
    end else if (stop) begin
      state_nx = IDLE;
      fcnt_nx  = '0;
    end else if (pause && (state == RUN)) begin
      state_nx = PAUSE;
    end else if (pause && (state == PAUSE)) begin
      state_nx = RUN;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state_nx = LOAD;
            ld_nx    = 1'b1;
            d_nx     = Y_INIT;
            dir_nx   = 1'b1;
            fcnt_nx  = '0;
          end
        end
        LOAD: state_nx = RUN;
        RUN: begin
          if (frame) begin
            if (fcnt == FLAST) begin
              fcnt_nx = '0;
              if (dir && (y >= Y_MAX)) begin
                dir_nx = 1'b0;
                dw_nx  = 1'b1;
              end else if (!dir && (y <= Y_MIN)) begin
                dir_nx = 1'b1;
                up_nx  = 1'b1;
              end else if (dir) begin
                up_nx = 1'b1;
              end else begin
                dw_nx = 1'b1;
              end
            end else begin
              fcnt_nx = fcnt + FW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      fcnt   <= '0;
      up     <= 1'b0;
      dw     <= 1'b0;
      ld     <= 1'b0;
      d      <= Y_INIT;
      dir    <= 1'b1;
      moving <= 1'b0;
    end else begin
      state  <= state_nx;
      fcnt   <= fcnt_nx;
      up     <= up_nx;
      dw     <= dw_nx;
      ld     <= ld_nx;
      d      <= d_nx;
      dir    <= dir_nx;
      moving <= (state_nx == RUN);
    end
  end

endmodule

// File: tb/tb_hline_move_ctrl.sv
// Directed bench for hline_move_ctrl with default parameters (STEP_FRAMES=2, 18..630, init 320).
module tb_hline_move_ctrl;

  logic        clk = 1'b0;
  logic        reset, frame, start, stop, pause, load_req;
  logic [15:0] load_val, y;
  logic        up, dw, ld, dir, moving;
  logic [15:0] d;

  int checks = 0;
  int errors = 0;
  int cnt;

  hline_move_ctrl dut (
    .clk(clk), .reset(reset), .frame(frame), .start(start), .stop(stop),
    .pause(pause), .load_req(load_req), .load_val(load_val), .y(y),
    .up(up), .dw(dw), .ld(ld), .d(d), .dir(dir), .moving(moving)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic frame_pulse();
    frame = 1'b1;
    tick();
    frame = 1'b0;
  endtask

  initial begin
    reset = 1'b1; frame = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
    load_req = 1'b0; load_val = 16'd0; y = 16'd320;
    tick(); tick();
    chk("rst_up", {15'd0, up}, 16'd0);
    chk("rst_dw", {15'd0, dw}, 16'd0);
    chk("rst_ld", {15'd0, ld}, 16'd0);
    chk("rst_d", d, 16'd320);
    chk("rst_dir", {15'd0, dir}, 16'd1);
    chk("rst_moving", {15'd0, moving}, 16'd0);
    reset = 1'b0;
    tick();

    // 1: start -> one ld cycle, then RUN; first frame produces no step
    start = 1'b1; tick(); start = 1'b0;
    chk("start_ld", {15'd0, ld}, 16'd1);
    chk("start_d", d, 16'd320);
    chk("start_moving_in_load", {15'd0, moving}, 16'd0);
    tick();
    chk("load_ld_drop", {15'd0, ld}, 16'd0);
    chk("run_moving", {15'd0, moving}, 16'd1);
    chk("run_dir", {15'd0, dir}, 16'd1);
    frame_pulse();
    chk("frame1_no_up", {15'd0, up}, 16'd0);
    tick();
    frame_pulse();
    chk("frame2_up", {15'd0, up}, 16'd1);
    chk("frame2_dw", {15'd0, dw}, 16'd0);
    tick();
    chk("up_one_cycle", {15'd0, up}, 16'd0);

    // 2: six frames at y=320 -> ups after frames 2, 4, 6 only
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      frame_pulse();
      chk($sformatf("seq_up_f%0d", i + 1), {15'd0, up}, (i % 2 == 1) ? 16'd1 : 16'd0);
      if (up) cnt++;
      tick();
      if (up || dw) cnt += 10;
    end
    chk("seq_up_count", cnt[15:0], 16'd3);

    // 3: bounce at both limits
    y = 16'd630;
    frame_pulse();
    frame_pulse();
    chk("top_dw", {15'd0, dw}, 16'd1);
    chk("top_up", {15'd0, up}, 16'd0);
    chk("top_dir", {15'd0, dir}, 16'd0);
    y = 16'd18;
    frame_pulse();
    frame_pulse();
    chk("bot_up", {15'd0, up}, 16'd1);
    chk("bot_dw", {15'd0, dw}, 16'd0);
    chk("bot_dir", {15'd0, dir}, 16'd1);
    y = 16'd320;

    // 4: pause holds the frame count
    frame_pulse();
    pause = 1'b1; tick(); pause = 1'b0;
    chk("pause_moving", {15'd0, moving}, 16'd0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      frame_pulse();
      if (up || dw || ld) cnt++;
    end
    chk("pause_no_strobes", cnt[15:0], 16'd0);
    pause = 1'b1; tick(); pause = 1'b0;
    chk("resume_moving", {15'd0, moving}, 16'd1);
    frame_pulse();
    chk("resume_remainder_up", {15'd0, up}, 16'd1);
    tick();

    // 5: clamped reloads and load_req beating a due step
    load_req = 1'b1; load_val = 16'd700; tick(); load_req = 1'b0;
    chk("clamp_hi_ld", {15'd0, ld}, 16'd1);
    chk("clamp_hi_d", d, 16'd630);
    tick();
    chk("clamp_hi_ld_drop", {15'd0, ld}, 16'd0);
    load_req = 1'b1; load_val = 16'd5; tick(); load_req = 1'b0;
    chk("clamp_lo_d", d, 16'd18);
    frame_pulse();
    chk("pre_collide_no_up", {15'd0, up}, 16'd0);
    frame = 1'b1; load_req = 1'b1; load_val = 16'd400; tick();
    frame = 1'b0; load_req = 1'b0;
    chk("collide_ld", {15'd0, ld}, 16'd1);
    chk("collide_d", d, 16'd400);
    chk("collide_no_up", {15'd0, up | dw}, 16'd0);
    chk("collide_moving", {15'd0, moving}, 16'd1);
    frame_pulse();
    chk("fcnt_cleared_no_up", {15'd0, up}, 16'd0);
    frame_pulse();
    chk("after_load_up", {15'd0, up}, 16'd1);

    // 6: stop+pause -> IDLE with dir kept; reset kills a pending ld
    y = 16'd630;
    frame_pulse();
    frame_pulse();
    chk("pre_stop_dir", {15'd0, dir}, 16'd0);
    stop = 1'b1; pause = 1'b1; tick(); stop = 1'b0; pause = 1'b0;
    chk("stop_moving", {15'd0, moving}, 16'd0);
    chk("stop_dir_kept", {15'd0, dir}, 16'd0);
    pause = 1'b1; tick(); pause = 1'b0;
    chk("idle_pause_ignored", {15'd0, moving}, 16'd0);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      frame_pulse();
      if (up || dw || ld) cnt++;
    end
    chk("idle_no_strobes", cnt[15:0], 16'd0);
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_ld", {15'd0, ld}, 16'd1);
    chk("restart_dir", {15'd0, dir}, 16'd1);
    reset = 1'b1; tick();
    chk("rst_in_load_ld", {15'd0, ld}, 16'd0);
    chk("rst_in_load_d", d, 16'd320);
    reset = 1'b0; tick();
    chk("rst_in_load_idle", {15'd0, moving}, 16'd0);
    load_req = 1'b1; load_val = 16'd500; reset = 1'b1; tick();
    load_req = 1'b0; reset = 1'b0;
    chk("rst_over_load_ld", {15'd0, ld}, 16'd0);
    chk("rst_over_load_d", d, 16'd320);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
